// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
//   ld_state_e : loader frame FSM states
//   rx_state_e : UART receiver FSM states
//   SYNC_BYTE  : frame start marker
//   baud_div() : clocks per UART bit, rounded to nearest
package prog_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StDatLo,
        StDatHi,
        StCsum,
        StDone,
        StErr
    } ld_state_e;

    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_prog_loader_if.sv
// Write-side bundle of the program BRAM port.
//   ram_ce   BRAM clock enable
//   ram_oce  BRAM output-register enable
//   ram_wre  BRAM write enable
//   ram_ad   word address
//   ram_din  write data
// master: loader drives the port; slave: BRAM / port mux side.
interface uart_prog_loader_if #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 16
);
    logic              ram_ce;
    logic              ram_oce;
    logic              ram_wre;
    logic [ADDR_W-1:0] ram_ad;
    logic [DATA_W-1:0] ram_din;

    modport master (output ram_ce, output ram_oce, output ram_wre, output ram_ad, output ram_din);
    modport slave  (input  ram_ce, input  ram_oce, input  ram_wre, input  ram_ad, input  ram_din);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver.
//   clk, reset   system clock, synchronous active-high reset
//   rx           asynchronous serial input, idle high
//   data         last received byte (valid while byte_valid=1, held afterwards)
//   byte_valid   1-cycle pulse: byte received with a good stop bit
//   frame_err    1-cycle pulse: stop bit sampled low
module uart_rx_byte
    import prog_loader_pkg::*;
#(
    parameter int unsigned CLK_HZ = 27_000_000,
    parameter int unsigned BAUD   = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_err
);
    localparam int unsigned DIV   = baud_div(CLK_HZ, BAUD);
    localparam int unsigned CNT_W = $clog2(DIV + 1);
    localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIV / 2 - 1);

    rx_state_e        st_q, st_d;
    logic [1:0]       sync_q;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             rx_s;

    assign rx_s = sync_q[1];

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (st_q)
            RxIdle: begin
                if (prev_q && !rx_s) begin
                    st_d  = RxStart;
                    cnt_d = HALF_M1;
                end
            end
            RxStart: begin
                if (cnt_q == '0) begin
                    // A start bit that is no longer low at mid-bit was a glitch.
                    if (!rx_s) begin
                        st_d  = RxData;
                        cnt_d = DIV_M1;
                        bit_d = 3'd0;
                    end else begin
                        st_d = RxIdle;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RxData: begin
                if (cnt_q == '0) begin
                    sh_d  = {rx_s, sh_q[7:1]};
                    cnt_d = DIV_M1;
                    if (bit_q == 3'd7) begin
                        st_d = RxStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RxStop: begin
                if (cnt_q == '0) begin
                    valid_d = rx_s;
                    ferr_d  = !rx_s;
                    st_d    = RxIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: st_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q    <= RxIdle;
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            sh_q    <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            sync_q  <= {sync_q[0], rx};
            prev_q  <= rx_s;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data       = sh_q;
    assign byte_valid = valid_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: receives a framed image over 8N1 UART and writes it as little-endian
// 16-bit words into the program BRAM starting at address 0, holding the CPU while loading.
// Frame: A5 | LEN_LO | LEN_HI | {LO,HI} x LEN [| CSUM]
// Optional feature macro: PROG_LOADER_CSUM_EN (adds a trailing XOR checksum byte).
//   clk           system clock
//   reset         synchronous active-high reset
//   uart_rx       serial input, idle high
//   ram           BRAM write port (uart_prog_loader_if.master)
//   cpu_hold      1 while a frame is being loaded
//   load_done     sticky: last frame completed
//   load_err      sticky: last frame aborted
//   words_loaded  words written in the current/last frame
// Assumes ADDR_W <= 15 so the length field covers 2**ADDR_W.
module uart_prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 27_000_000,
    parameter int unsigned BAUD        = 115_200,
    parameter int unsigned ADDR_W      = 11,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned TIMEOUT_CYC = CLK_HZ / 100
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                uart_rx,
    uart_prog_loader_if.master  ram,
    output logic                cpu_hold,
    output logic                load_done,
    output logic                load_err,
    output logic [ADDR_W:0]     words_loaded
);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC);
    localparam logic [15:0] MAX_WORDS = 16'(2 ** ADDR_W);
`ifdef PROG_LOADER_CSUM_EN
    localparam ld_state_e END_ST = StCsum;
`else
    localparam ld_state_e END_ST = StDone;
`endif

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       frame_err;

    uart_rx_byte #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx         (uart_rx),
        .data       (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    ld_state_e         st_q, st_d;
    logic [7:0]        lo_q, lo_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              wre_q, wre_d;
    logic [ADDR_W-1:0] ad_q, ad_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [15:0]       len_full;
    logic              busy;

    assign busy     = st_q inside {StLenLo, StLenHi, StDatLo, StDatHi, StCsum};
    assign len_full = {rx_byte, lo_q};

`ifdef PROG_LOADER_CSUM_EN
    logic [7:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (byte_valid) begin
            case (st_q)
                StIdle:                             csum_d = 8'h00;
                StLenLo, StLenHi, StDatLo, StDatHi: csum_d = csum_q ^ rx_byte;
                default:                            csum_d = csum_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q <= 8'h00;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    always_comb begin
        st_d   = st_q;
        lo_d   = lo_q;
        len_d  = len_q;
        cnt_d  = cnt_q;
        hold_d = hold_q;
        done_d = done_q;
        err_d  = err_q;
        wre_d  = 1'b0;
        ad_d   = ad_q;
        din_d  = din_q;

        // Inter-byte gap counter, only meaningful inside a frame.
        if (!busy || byte_valid || frame_err) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_MAX) begin
            tmo_d = tmo_q;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        case (st_q)
            StIdle: begin
                if (byte_valid && rx_byte == SYNC_BYTE) begin
                    st_d   = StLenLo;
                    hold_d = 1'b1;
                    done_d = 1'b0;
                    err_d  = 1'b0;
                    cnt_d  = '0;
                end
            end
            StLenLo: begin
                if (byte_valid) begin
                    lo_d = rx_byte;
                    st_d = StLenHi;
                end
            end
            StLenHi: begin
                if (byte_valid) begin
                    len_d = len_full[ADDR_W:0];
                    if (len_full > MAX_WORDS) begin
                        st_d = StErr;
                    end else if (len_full == 16'h0000) begin
                        st_d = END_ST;
                    end else begin
                        st_d = StDatLo;
                    end
                end
            end
            StDatLo: begin
                if (byte_valid) begin
                    lo_d = rx_byte;
                    st_d = StDatHi;
                end
            end
            StDatHi: begin
                if (byte_valid) begin
                    wre_d = 1'b1;
                    ad_d  = cnt_q[ADDR_W-1:0];
                    din_d = DATA_W'({rx_byte, lo_q});
                    cnt_d = cnt_q + 1'b1;
                    st_d  = (cnt_d == len_q) ? END_ST : StDatLo;
                end
            end
            StCsum: begin
`ifdef PROG_LOADER_CSUM_EN
                if (byte_valid) begin
                    st_d = (rx_byte == csum_q) ? StDone : StErr;
                end
`else
                st_d = StDone;
`endif
            end
            StDone: begin
                done_d = 1'b1;
                hold_d = 1'b0;
                st_d   = StIdle;
            end
            StErr: begin
                err_d  = 1'b1;
                hold_d = 1'b0;
                st_d   = StIdle;
            end
            default: st_d = StIdle;
        endcase

        // A byte arriving on the timeout cycle takes priority over the timeout.
        if (busy && !byte_valid && (frame_err || tmo_q == TMO_MAX)) begin
            st_d = StErr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q   <= StIdle;
            lo_q   <= 8'h00;
            len_q  <= '0;
            cnt_q  <= '0;
            tmo_q  <= '0;
            hold_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            wre_q  <= 1'b0;
            ad_q   <= '0;
            din_q  <= '0;
        end else begin
            st_q   <= st_d;
            lo_q   <= lo_d;
            len_q  <= len_d;
            cnt_q  <= cnt_d;
            tmo_q  <= tmo_d;
            hold_q <= hold_d;
            done_q <= done_d;
            err_q  <= err_d;
            wre_q  <= wre_d;
            ad_q   <= ad_d;
            din_q  <= din_d;
        end
    end

    assign ram.ram_ce   = wre_q;
    assign ram.ram_wre  = wre_q;
    assign ram.ram_oce  = 1'b0;
    assign ram.ram_ad   = ad_q;
    assign ram.ram_din  = din_q;
    assign cpu_hold     = hold_q;
    assign load_done    = done_q;
    assign load_err     = err_q;
    assign words_loaded = cnt_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader. Uses a fast baud (10 clocks/bit) and a short
// inter-byte timeout to keep frames short. Follows PROG_LOADER_CSUM_EN if defined.
module tb_uart_prog_loader;
    localparam int unsigned CLK_HZ      = 1_000_000;
    localparam int unsigned BAUD        = 100_000;
    localparam int unsigned ADDR_W      = 11;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned TIMEOUT_CYC = 300;
    localparam int unsigned BIT_CLKS    = 10;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              uart_rx = 1'b1;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   words_loaded;

    uart_prog_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ram ();

    uart_prog_loader #(
        .CLK_HZ      (CLK_HZ),
        .BAUD        (BAUD),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .uart_rx      (uart_rx),
        .ram          (ram),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Write log, sampled just after each rising edge.
    int                wr_n = 0;
    int                ce_bad = 0;
    int                wide = 0;
    logic              wre_prev = 1'b0;
    logic [ADDR_W-1:0] log_ad [16];
    logic [DATA_W-1:0] log_din [16];

    always @(posedge clk) begin
        #1;
        if (ram.ram_ce !== ram.ram_wre) ce_bad++;
        if (ram.ram_wre === 1'b1 && wre_prev) wide++;
        wre_prev = (ram.ram_wre === 1'b1);
        if (ram.ram_wre === 1'b1) begin
            if (wr_n < 16) begin
                log_ad[wr_n]  = ram.ram_ad;
                log_din[wr_n] = ram.ram_din;
            end
            wr_n++;
        end
    end

    logic [7:0] frame_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk) uart_rx = 1'b0;
        repeat (BIT_CLKS - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) uart_rx = b[i];
            repeat (BIT_CLKS - 1) @(negedge clk);
        end
        @(negedge clk) uart_rx = 1'b1;
        repeat (2 * BIT_CLKS - 1) @(negedge clk);
    endtask

    task automatic send_q();
        for (int i = 0; i < frame_q.size(); i++) send_byte(frame_q[i]);
        frame_q.delete();
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (!(load_done || load_err) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_wait"}, 32'(n < 500), 32'd1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        reset   = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_wre", ram.ram_wre, 0);
        chk("rst_ce", ram.ram_ce, 0);
        chk("rst_oce", ram.ram_oce, 0);
        chk("rst_ad", ram.ram_ad, 0);
        chk("rst_din", ram.ram_din, 0);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_done", load_done, 0);
        chk("rst_err", load_err, 0);
        chk("rst_words", words_loaded, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // 1: three-word frame
        wr_n = 0;
        send_byte(8'hA5);
        chk("t1_hold", cpu_hold, 1);
        frame_q = '{8'h03, 8'h00, 8'hA1, 8'h78, 8'h66, 8'h90, 8'h00, 8'h00};
`ifdef PROG_LOADER_CSUM_EN
        frame_q.push_back(8'h2C);
`endif
        send_q();
        wait_end("t1");
        chk("t1_done", load_done, 1);
        chk("t1_err", load_err, 0);
        chk("t1_hold_end", cpu_hold, 0);
        chk("t1_words", words_loaded, 3);
        chk("t1_nwr", wr_n, 3);
        chk("t1_ad0", log_ad[0], 0);
        chk("t1_din0", log_din[0], 16'h78A1);
        chk("t1_ad1", log_ad[1], 1);
        chk("t1_din1", log_din[1], 16'h9066);
        chk("t1_ad2", log_ad[2], 2);
        chk("t1_din2", log_din[2], 16'h0000);
        chk("t1_ad_hold", ram.ram_ad, 2);

        // 2: same frame; bad checksum when enabled, trailing stray byte otherwise
        wr_n = 0;
        frame_q = '{8'hA5, 8'h03, 8'h00, 8'hA1, 8'h78, 8'h66, 8'h90, 8'h00, 8'h00};
`ifdef PROG_LOADER_CSUM_EN
        frame_q.push_back(8'hD3);
        send_q();
        wait_end("t2");
        chk("t2_err", load_err, 1);
        chk("t2_done", load_done, 0);
`else
        send_q();
        wait_end("t2");
        send_byte(8'hD3);
        chk("t2_err", load_err, 0);
        chk("t2_done", load_done, 1);
`endif
        chk("t2_hold", cpu_hold, 0);
        chk("t2_nwr", wr_n, 3);
        chk("t2_words", words_loaded, 3);

        // 3: zero-length frame
        wr_n = 0;
        frame_q = '{8'hA5, 8'h00, 8'h00};
`ifdef PROG_LOADER_CSUM_EN
        frame_q.push_back(8'h00);
`endif
        send_q();
        wait_end("t3");
        chk("t3_done", load_done, 1);
        chk("t3_err", load_err, 0);
        chk("t3_words", words_loaded, 0);
        chk("t3_nwr", wr_n, 0);

        // 4: LEN = 2049 is one past capacity
        wr_n = 0;
        frame_q = '{8'hA5, 8'h01, 8'h08};
        send_q();
        wait_end("t4");
        chk("t4_err", load_err, 1);
        chk("t4_done", load_done, 0);
        chk("t4_hold", cpu_hold, 0);
        chk("t4_nwr", wr_n, 0);

        // 5: line goes quiet after first word -> timeout, then a good frame
        wr_n = 0;
        frame_q = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22};
        send_q();
        chk("t5_hold_mid", cpu_hold, 1);
        chk("t5_err_mid", load_err, 0);
        repeat (TIMEOUT_CYC + 50) @(negedge clk);
        chk("t5_err", load_err, 1);
        chk("t5_done", load_done, 0);
        chk("t5_hold", cpu_hold, 0);
        chk("t5_nwr", wr_n, 1);
        chk("t5_din0", log_din[0], 16'h2211);
        chk("t5_words", words_loaded, 1);
        wr_n = 0;
        frame_q = '{8'hA5, 8'h01, 8'h00, 8'h33, 8'h44};
`ifdef PROG_LOADER_CSUM_EN
        frame_q.push_back(8'h76);
`endif
        send_q();
        wait_end("t5b");
        chk("t5b_done", load_done, 1);
        chk("t5b_err", load_err, 0);
        chk("t5b_nwr", wr_n, 1);
        chk("t5b_ad0", log_ad[0], 0);
        chk("t5b_din0", log_din[0], 16'h4433);

        // 6: garbage in idle is ignored, then a valid frame
        wr_n = 0;
        frame_q = '{8'h00, 8'hFF, 8'h12};
        send_q();
        chk("t6_idle_hold", cpu_hold, 0);
        chk("t6_idle_nwr", wr_n, 0);
        chk("t6_idle_done", load_done, 1);
        frame_q = '{8'hA5, 8'h02, 8'h00, 8'h55, 8'h66, 8'h77, 8'h88};
`ifdef PROG_LOADER_CSUM_EN
        frame_q.push_back(8'hCE);
`endif
        send_q();
        wait_end("t6");
        chk("t6_done", load_done, 1);
        chk("t6_nwr", wr_n, 2);
        chk("t6_din0", log_din[0], 16'h6655);
        chk("t6_ad1", log_ad[1], 1);
        chk("t6_din1", log_din[1], 16'h8877);
        chk("t6_words", words_loaded, 2);

        // 6b: reset while receiving the first LO byte
        wr_n = 0;
        frame_q = '{8'hA5, 8'h01, 8'h00};
        send_q();
        chk("t6r_hold_pre", cpu_hold, 1);
        chk("t6r_done_pre", load_done, 0);
        @(negedge clk) uart_rx = 1'b0;
        repeat (3 * BIT_CLKS) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t6r_hold", cpu_hold, 0);
        chk("t6r_done", load_done, 0);
        chk("t6r_err", load_err, 0);
        chk("t6r_words", words_loaded, 0);
        chk("t6r_wre", ram.ram_wre, 0);
        chk("t6r_ad", ram.ram_ad, 0);
        chk("t6r_din", ram.ram_din, 0);
        reset   = 1'b0;
        uart_rx = 1'b1;
        repeat (20 * BIT_CLKS) @(negedge clk);
        chk("t6r_quiet_hold", cpu_hold, 0);
        chk("t6r_quiet_nwr", wr_n, 0);

        // Whole-run strobe properties
        chk("ce_eq_wre", ce_bad, 0);
        chk("wre_one_cycle", wide, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
